// File: rtl/frog_referee.sv
// Game judge for the frog-position stage: rotating obstacle lane, collision/goal
// detection, lives and score bookkeeping, and the frog_reset request back upstream.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   PLAY  | obstacles rotate, frog is judged every cycle
//   HIT   | collision recovery, frog_reset held, obstacles frozen
//   WIN   | goal recovery, frog_reset held, obstacles frozen
//   OVER  | no lives left, frog_reset held until restart
module frog_referee #(
    parameter int          TICK_DIV  = 25_000_000,
    parameter int          HOLD_CYC  = 16,
    parameter int          LIVES     = 3,
    parameter logic [16:0] OBST_INIT = 17'h00421
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] frog,
    input  logic        restart,
    output logic        frog_reset,
    output logic [18:0] obst,
    output logic [1:0]  lives,
    output logic [7:0]  score,
    output logic        hit_pulse,
    output logic        win_pulse,
    output logic        game_over
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYC - 1);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {
        S_PLAY,
        S_HIT,
        S_WIN,
        S_OVER
    } state_t;

    state_t         state, state_nxt;
    logic [16:0]    ring, ring_nxt;
    logic [TW-1:0]  tick_cnt, tick_cnt_nxt;
    logic [HW-1:0]  hold_cnt, hold_cnt_nxt;
    logic [1:0]     lives_nxt;
    logic [7:0]     score_nxt;
    logic           frog_reset_nxt;
    logic           hit_pulse_nxt;
    logic           win_pulse_nxt;

    logic           tick;
    logic           frog_valid;
    logic           collide;
    logic           at_goal;

    assign obst      = {1'b0, ring, 1'b0};
    assign game_over = (state == S_OVER);

    assign tick       = (tick_cnt == TICK_LAST);
    // Garbage frog vectors (none or several bits set) are never judged.
    assign frog_valid = (frog != 19'd0) && ((frog & (frog - 19'd1)) == 19'd0);
    assign collide    = frog_valid && ((frog & obst) != 19'd0);
    assign at_goal    = frog_valid && frog[18];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_PLAY;
            ring       <= OBST_INIT;
            tick_cnt   <= '0;
            hold_cnt   <= '0;
            lives      <= LIVES_INIT;
            score      <= 8'd0;
            frog_reset <= 1'b0;
            hit_pulse  <= 1'b0;
            win_pulse  <= 1'b0;
        end else begin
            state      <= state_nxt;
            ring       <= ring_nxt;
            tick_cnt   <= tick_cnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            lives      <= lives_nxt;
            score      <= score_nxt;
            frog_reset <= frog_reset_nxt;
            hit_pulse  <= hit_pulse_nxt;
            win_pulse  <= win_pulse_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ring_nxt       = ring;
        tick_cnt_nxt   = tick_cnt;
        hold_cnt_nxt   = hold_cnt;
        lives_nxt      = lives;
        score_nxt      = score;
        frog_reset_nxt = frog_reset;
        hit_pulse_nxt  = 1'b0;
        win_pulse_nxt  = 1'b0;

        case (state)
            S_PLAY: begin
                // The lane keeps moving on the very cycle a hit or win is judged.
                if (tick) begin
                    tick_cnt_nxt = '0;
                    ring_nxt     = {ring[15:0], ring[16]};
                end else begin
                    tick_cnt_nxt = tick_cnt + 1'b1;
                end

                if (collide) begin
                    state_nxt      = S_HIT;
                    hit_pulse_nxt  = 1'b1;
                    frog_reset_nxt = 1'b1;
                    hold_cnt_nxt   = HOLD_LOAD;
                    if (lives != 2'd0) begin
                        lives_nxt = lives - 2'd1;
                    end
                end else if (at_goal) begin
                    state_nxt      = S_WIN;
                    win_pulse_nxt  = 1'b1;
                    frog_reset_nxt = 1'b1;
                    hold_cnt_nxt   = HOLD_LOAD;
                    if (score != 8'hFF) begin
                        score_nxt = score + 8'd1;
                    end
                end
            end

            S_HIT, S_WIN: begin
                frog_reset_nxt = 1'b1;
                if (hold_cnt == '0) begin
                    if ((state == S_HIT) && (lives == 2'd0)) begin
                        state_nxt = S_OVER;
                    end else begin
                        state_nxt      = S_PLAY;
                        frog_reset_nxt = 1'b0;
                        tick_cnt_nxt   = '0;
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt - 1'b1;
                end
            end

            S_OVER: begin
                frog_reset_nxt = 1'b1;
                if (restart) begin
                    state_nxt      = S_PLAY;
                    lives_nxt      = LIVES_INIT;
                    score_nxt      = 8'd0;
                    ring_nxt       = OBST_INIT;
                    tick_cnt_nxt   = '0;
                    frog_reset_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = S_PLAY;
            end
        endcase
    end

endmodule

// File: tb/tb_frog_referee.sv
// Scoreboard bench for frog_referee: expected strobes are queued as stimulus is
// driven and popped when hit_pulse/win_pulse appear; level checks go inline.
module tb_frog_referee;

    logic        clk;
    logic        rst;
    logic [18:0] frog;
    logic        restart;
    logic        frog_reset;
    logic [18:0] obst;
    logic [1:0]  lives;
    logic [7:0]  score;
    logic        hit_pulse;
    logic        win_pulse;
    logic        game_over;

    typedef struct {
        logic       is_win;
        logic [1:0] lives;
        logic [7:0] score;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    frog_referee #(
        .TICK_DIV (4),
        .HOLD_CYC (3),
        .LIVES    (3),
        .OBST_INIT(17'h00001)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frog      (frog),
        .restart   (restart),
        .frog_reset(frog_reset),
        .obst      (obst),
        .lives     (lives),
        .score     (score),
        .hit_pulse (hit_pulse),
        .win_pulse (win_pulse),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic is_win, input logic [1:0] lv, input logic [7:0] sc);
        exp_t e;
        e.is_win = is_win;
        e.lives  = lv;
        e.score  = sc;
        expq.push_back(e);
    endtask

    // Counts frog_reset high cycles; sends the frog home once the request is seen.
    task automatic hold_len(input logic [18:0] back, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frog_reset) begin
                n++;
                frog = back;
            end else if (n > 0) begin
                break;
            end
        end
    endtask

    task automatic wait_play();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!frog_reset) break;
        end
        chk("resume_play", frog_reset, 0);
    endtask

    // Strobe monitor: every pulse must match the next queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (hit_pulse || win_pulse) begin
                if (expq.size() == 0) begin
                    chk("unexpected_strobe", {hit_pulse, win_pulse}, 2'b00);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("strobe_kind", {hit_pulse, win_pulse}, e.is_win ? 2'b01 : 2'b10);
                    chk("strobe_lives", lives, e.lives);
                    chk("strobe_score", score, e.score);
                end
            end
        end
    end

    initial begin
        int n;
        rst     = 1'b0;
        frog    = 19'h00001;
        restart = 1'b0;

        // 1: reset values and obstacle rotation
        step(2);
        chk("rst_obst", obst, 19'h00002);
        chk("rst_lives", lives, 3);
        chk("rst_score", score, 0);
        chk("rst_frog_reset", frog_reset, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_pulses", {hit_pulse, win_pulse}, 0);
        rst = 1'b1;
        step(3);
        chk("rot_before_tick", obst, 19'h00002);
        step(1);
        chk("rot_tick1", obst, 19'h00004);
        step(4);
        chk("rot_tick2", obst, 19'h00008);
        chk("rot_lives", lives, 3);

        // 2: collision on bit 3
        frog = 19'h00008;
        push_exp(1'b0, 2'd2, 8'd0);
        hold_len(19'h00001, n);
        chk("hit_hold_len", n, 3);
        chk("hit_lives", lives, 2);
        step(3);
        chk("hit_cnt_zero", obst, 19'h00008);
        step(1);
        chk("hit_cnt_wrap", obst, 19'h00010);

        // 3: goal, then run the score into saturation
        frog = 19'h40000;
        push_exp(1'b1, 2'd2, 8'd1);
        hold_len(19'h00001, n);
        chk("win_hold_len", n, 3);
        chk("win_score", score, 1);
        for (int k = 2; k <= 258; k++) push_exp(1'b1, 2'd2, (k > 255) ? 8'd255 : 8'(k));
        frog = 19'h40000;
        for (int i = 0; i < 1500; i++) begin
            if (expq.size() == 0) break;
            @(negedge clk);
        end
        chk("sat_drain", expq.size(), 0);
        frog = 19'h00001;
        wait_play();
        chk("sat_score", score, 255);
        chk("sat_lives", lives, 2);

        // 5: invalid frog vectors are never judged; restart ignored in PLAY
        frog = 19'h00030;
        step(2);
        frog = 19'h7FFFF;
        step(2);
        chk("inv_obst", obst, 19'h00020);
        chk("inv_lives", lives, 2);
        chk("inv_score", score, 255);
        chk("inv_frog_reset", frog_reset, 0);
        frog    = 19'h00000;
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("restart_ign_lives", lives, 2);
        chk("restart_ign_score", score, 255);
        frog = 19'h00006;
        step(1);
        chk("inv6_lives", lives, 2);

        // 6: asynchronous reset in the middle of HIT
        frog = 19'h00020;
        push_exp(1'b0, 2'd1, 8'd255);
        step(1);
        chk("mid_hit_frog_reset", frog_reset, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_frog_reset", frog_reset, 0);
        chk("arst_lives", lives, 3);
        chk("arst_score", score, 0);
        chk("arst_obst", obst, 19'h00002);
        chk("arst_pulses", {hit_pulse, win_pulse, game_over}, 0);
        frog = 19'h00001;
        step(2);
        rst = 1'b1;

        // 4: win, three hits, game over, restart
        frog = 19'h40000;
        push_exp(1'b1, 2'd3, 8'd1);
        hold_len(19'h00001, n);
        chk("g_win_hold", n, 3);
        frog = 19'h00002;
        push_exp(1'b0, 2'd2, 8'd1);
        hold_len(19'h00001, n);
        chk("g_hit1_hold", n, 3);
        frog = 19'h00002;
        push_exp(1'b0, 2'd1, 8'd1);
        hold_len(19'h00001, n);
        chk("g_hit2_hold", n, 3);
        step(4);
        chk("g_obst_moved", obst, 19'h00004);
        frog = 19'h00004;
        push_exp(1'b0, 2'd0, 8'd1);
        step(1);
        frog = 19'h00001;
        step(3);
        chk("over_game_over", game_over, 1);
        chk("over_lives", lives, 0);
        chk("over_frog_reset", frog_reset, 1);
        frog = 19'h00004;
        for (int i = 0; i < 4; i++) begin
            step(5);
            chk("over_frozen", obst, 19'h00004);
            chk("over_held", {frog_reset, game_over}, 2'b11);
        end
        frog    = 19'h00001;
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("restart_lives", lives, 3);
        chk("restart_score", score, 0);
        chk("restart_obst", obst, 19'h00002);
        chk("restart_flags", {frog_reset, game_over}, 0);
        step(3);
        chk("restart_cnt_zero", obst, 19'h00002);
        step(1);
        chk("restart_tick", obst, 19'h00004);

        step(2);
        chk("queue_empty", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
